// File: rtl/usb_tx_sched.sv
// USB transmit scheduler: round-robin grant among packet sources, then SYNC/PID/payload
// serialization LSB-first, EOP request and inter-packet gap, frozen by the stuffer's stall.
module usb_tx_sched #(
    parameter  int NREQ       = 3,
    parameter  int MAX_BITS   = 64,
    parameter  int IFG_CYCLES = 2,
    localparam int LENW       = $clog2(MAX_BITS + 1)
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*8-1:0]        pid,
    input  logic [NREQ*MAX_BITS-1:0] payload,
    input  logic [NREQ*LENW-1:0]     len,
    input  logic                     stall,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          done,
    output logic                     bit_out,
    output logic                     bit_valid,
    output logic                     start,
    output logic                     eop,
    output logic                     busy
);

    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int IDXW = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SYNC = 3'd1;
    localparam logic [2:0] S_PID  = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_EOP  = 3'd4;
    localparam logic [2:0] S_GAP  = 3'd5;

    localparam logic [LENW-1:0] CNT_ONE       = LENW'(1);
    localparam logic [LENW-1:0] CNT_BYTE_LAST = LENW'(7);
    localparam logic [LENW-1:0] LEN_MAX       = LENW'(MAX_BITS);

    logic [2:0]          state;
    logic [LENW-1:0]     cnt;
    logic [LENW-1:0]     len_q;
    logic [PW-1:0]       ptr;
    logic [PW-1:0]       win;
    logic [PW-1:0]       win_q;
    logic                found;
    logic [7:0]          pid_q;
    logic [7:0]          sel_pid;
    logic [MAX_BITS-1:0] payload_q;
    logic [MAX_BITS-1:0] sel_payload;
    logic [LENW-1:0]     sel_len;
    logic [LENW-1:0]     len_clamped;
    logic                last_bit_q;
    logic                cur_bit;
    logic                in_bits;
    logic                gap_last;

    // Two passes: indices at/after the pointer first, then the wrapped-around ones.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (PW'(i) >= ptr)) begin
                found = 1'b1;
                win   = PW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i]) begin
                found = 1'b1;
                win   = PW'(i);
            end
        end
    end

    always_comb begin
        sel_pid     = '0;
        sel_payload = '0;
        sel_len     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == PW'(i)) begin
                sel_pid     = pid[8*i +: 8];
                sel_payload = payload[MAX_BITS*i +: MAX_BITS];
                sel_len     = len[LENW*i +: LENW];
            end
        end
        len_clamped = (sel_len > LEN_MAX) ? LEN_MAX : sel_len;
    end

    always_comb begin
        case (state)
            S_SYNC:  cur_bit = (cnt == CNT_BYTE_LAST);
            S_PID:   cur_bit = pid_q[cnt[2:0]];
            S_DATA:  cur_bit = payload_q[cnt[IDXW-1:0]];
            default: cur_bit = 1'b0;
        endcase
    end

    // gnt is gated by rst_b so a held request cannot show a grant while in reset.
    always_comb begin
        gnt = '0;
        if ((state == S_IDLE) && found && rst_b) gnt[win] = 1'b1;
        done = '0;
        if ((state == S_EOP) && (cnt == CNT_ONE)) done[win_q] = 1'b1;
    end

    assign in_bits   = (state == S_SYNC) || (state == S_PID) || (state == S_DATA);
    assign bit_valid = in_bits && !stall;
    assign bit_out   = in_bits && (stall ? last_bit_q : cur_bit);
    assign start     = (state == S_SYNC) && (cnt == '0) && !stall;
    assign eop       = (state == S_EOP);
    assign busy      = (state != S_IDLE);
    assign gap_last  = (int'(cnt) >= IFG_CYCLES - 1);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state      <= S_IDLE;
            cnt        <= '0;
            len_q      <= '0;
            ptr        <= '0;
            win_q      <= '0;
            pid_q      <= '0;
            payload_q  <= '0;
            last_bit_q <= 1'b0;
        end else begin
            if (in_bits && !stall) last_bit_q <= cur_bit;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        state      <= S_SYNC;
                        cnt        <= '0;
                        win_q      <= win;
                        ptr        <= (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
                        pid_q      <= sel_pid;
                        payload_q  <= sel_payload;
                        len_q      <= len_clamped;
                        last_bit_q <= 1'b0;
                    end
                end
                S_SYNC: begin
                    if (!stall) begin
                        if (cnt == CNT_BYTE_LAST) begin
                            state <= S_PID;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end
                S_PID: begin
                    if (!stall) begin
                        if (cnt == CNT_BYTE_LAST) begin
                            state <= (len_q != '0) ? S_DATA : S_EOP;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end
                S_DATA: begin
                    if (!stall) begin
                        if (cnt == len_q - CNT_ONE) begin
                            state <= S_EOP;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end
                S_EOP: begin
                    if (cnt == CNT_ONE) begin
                        state <= (IFG_CYCLES > 0) ? S_GAP : S_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_GAP: begin
                    if (gap_last) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx_sched.sv
// Bench for usb_tx_sched: directed scenarios plus randomized packets, checked cycle by
// cycle against a packet-level model (bit list, round-robin pointer, EOP/gap timing).
module tb_usb_tx_sched;

    localparam int NREQ     = 3;
    localparam int MAX_BITS = 64;
    localparam int IFG      = 2;
    localparam int LENW     = 7;

    logic                     clk = 1'b0;
    logic                     rst_b;
    logic [NREQ-1:0]          req;
    logic [NREQ*8-1:0]        pid;
    logic [NREQ*MAX_BITS-1:0] payload;
    logic [NREQ*LENW-1:0]     len;
    logic                     stall;
    logic [NREQ-1:0]          gnt;
    logic [NREQ-1:0]          done;
    logic                     bit_out;
    logic                     bit_valid;
    logic                     start;
    logic                     eop;
    logic                     busy;

    logic [7:0]          pid_a [NREQ];
    logic [63:0]         pay_a [NREQ];
    logic [LENW-1:0]     len_a [NREQ];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rr     = 0;

    usb_tx_sched #(.NREQ(NREQ), .MAX_BITS(MAX_BITS), .IFG_CYCLES(IFG)) dut (
        .clk(clk), .rst_b(rst_b), .req(req), .pid(pid), .payload(payload), .len(len),
        .stall(stall), .gnt(gnt), .done(done), .bit_out(bit_out), .bit_valid(bit_valid),
        .start(start), .eop(eop), .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        pid     = '0;
        payload = '0;
        len     = '0;
        for (int i = 0; i < NREQ; i++) begin
            pid[8*i +: 8]               = pid_a[i];
            payload[MAX_BITS*i +: MAX_BITS] = pay_a[i];
            len[LENW*i +: LENW]         = len_a[i];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [10:0] outs();
        return {gnt, done, bit_out, bit_valid, start, eop, busy};
    endfunction

    function automatic logic [10:0] expv(input logic [2:0] g, input logic [2:0] d,
                                         input logic bo, input logic bv, input logic st,
                                         input logic e, input logic b);
        return {g, d, bo, bv, st, e, b};
    endfunction

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle_check(input string tag);
        tick();
        req   = '0;
        stall = 1'($urandom_range(0, 1));
        #1;
        check(tag, outs(), '0);
    endtask

    task automatic rand_contents();
        for (int i = 0; i < NREQ; i++) begin
            pid_a[i] = 8'($urandom);
            pay_a[i] = {$urandom, $urandom};
            len_a[i] = LENW'($urandom_range(0, 100));
        end
    endtask

    // One full transaction: grant cycle, bit stream, EOP, gap. mode 0 no stall,
    // 1 two-cycle stall after the third PID bit, 2 random stalls everywhere.
    task automatic run_packet(input logic [2:0] rq, input int mode, input bit drop,
                              input bit scr, output int w, output int gc, output int dc);
        bit       q[$];
        int       ln;
        int       sent;
        int       nstall;
        int       idx;
        logic     last;
        logic     s;
        logic     b;
        logic [2:0] wmask;
        bit       fresh;

        tick();
        req   = rq;
        stall = 1'($urandom_range(0, 1));
        #1;
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
            idx = (rr + k) % NREQ;
            if (w < 0 && rq[idx]) w = idx;
        end
        wmask = 3'(1 << w);
        check("grant", outs(), expv(wmask, 3'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        gc = cyc;
        rr = (w + 1) % NREQ;
        ln = (int'(len_a[w]) > MAX_BITS) ? MAX_BITS : int'(len_a[w]);
        for (int i = 0; i < 7; i++) q.push_back(1'b0);
        q.push_back(1'b1);
        for (int i = 0; i < 8; i++) q.push_back(pid_a[w][i]);
        for (int i = 0; i < ln; i++) q.push_back(pay_a[w][i]);

        sent = 0; nstall = 0; last = 1'b0; fresh = 1'b1;
        while (q.size() > 0) begin
            tick();
            if (fresh) begin
                fresh = 1'b0;
                if (drop) req[w] = 1'b0;
                if (scr) begin
                    pid_a[w] = 8'($urandom);
                    pay_a[w] = {$urandom, $urandom};
                    len_a[w] = LENW'($urandom_range(0, 100));
                end
            end
            if (mode == 2)      s = ($urandom_range(0, 3) == 0) && (nstall < 40);
            else if (mode == 1) s = (sent == 11) && (nstall < 2);
            else                s = 1'b0;
            stall = s;
            #1;
            if (s) begin
                nstall++;
                check("stall", outs(), expv(3'b0, 3'b0, last, 1'b0, 1'b0, 1'b0, 1'b1));
            end else begin
                b = q.pop_front();
                check("bit", outs(), expv(3'b0, 3'b0, b, 1'b1, sent == 0, 1'b0, 1'b1));
                last = b;
                sent++;
            end
        end
        dc = -1;
        for (int e = 0; e < 2; e++) begin
            tick();
            stall = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            check("eop", outs(), expv(3'b0, (e == 1) ? wmask : 3'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
            if (e == 1) dc = cyc;
        end
        for (int g = 0; g < IFG; g++) begin
            tick();
            stall = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            check("gap", outs(), expv(3'b0, 3'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        end
        check("done_latency", 64'(dc - gc), 64'(18 + ln + nstall));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int w, gc, dc, prev;
        int rr_exp [4];
        rr_exp = '{0, 1, 2, 0};
        rst_b = 1'b0;
        req   = 3'b111;
        stall = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            pid_a[i] = '0; pay_a[i] = '0; len_a[i] = '0;
        end

        tick();
        #1;
        check("reset_outs", outs(), '0);
        tick();
        rst_b = 1'b1;
        req   = '0;
        #1;
        check("post_reset_idle", outs(), '0);
        rr = 0;

        // Round-robin with all requesters held, zero-length packets.
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            run_packet(3'b111, 0, 1'b0, 1'b0, w, gc, dc);
            check("rr_order", 64'(w), 64'(rr_exp[k]));
            if (k > 0) check("rr_spacing", 64'(gc - prev), 64'd21);
            prev = gc;
        end
        idle_check("rr_idle");

        // Single directed packet, request dropped right after the grant.
        pid_a[0] = 8'hA5; pay_a[0] = 64'hB; len_a[0] = 7'd4;
        run_packet(3'b001, 0, 1'b1, 1'b1, w, gc, dc);
        check("single_winner", 64'(w), 64'd0);
        check("single_done_cyc", 64'(dc - gc), 64'd22);
        idle_check("single_no_regrant");
        check("single_busy_low_cyc", 64'(cyc - gc), 64'd25);

        // Stall for two cycles after the third PID bit.
        pid_a[2] = 8'h3C; pay_a[2] = 64'h5A; len_a[2] = 7'd8;
        run_packet(3'b100, 1, 1'b0, 1'b1, w, gc, dc);
        check("stall_winner", 64'(w), 64'd2);
        check("stall_done_cyc", 64'(dc - gc), 64'd28);
        idle_check("stall_idle");

        // len = 0 and len above MAX_BITS.
        len_a[1] = 7'd0; pid_a[1] = 8'hC3;
        run_packet(3'b010, 2, 1'b1, 1'b1, w, gc, dc);
        check("len0_winner", 64'(w), 64'd1);
        idle_check("len0_idle");
        len_a[0] = 7'd100; pay_a[0] = 64'hFEDC_BA98_7654_3210;
        run_packet(3'b001, 0, 1'b1, 1'b1, w, gc, dc);
        check("clamp_done_cyc", 64'(dc - gc), 64'd82);
        idle_check("clamp_idle");

        // Randomized traffic.
        for (int n = 0; n < 20; n++) begin
            rand_contents();
            run_packet(3'($urandom_range(1, 7)), 2, 1'($urandom_range(0, 1)), 1'b1, w, gc, dc);
            if ($urandom_range(0, 2) == 0) idle_check("rand_idle");
        end

        // Reset in the middle of DATA.
        idle_check("pre_rst_idle");
        len_a[0] = 7'd40;
        tick();
        req   = 3'b001;
        stall = 1'b0;
        #1;
        check("rst_test_grant", 64'(gnt), 64'(1 << rr_first(3'b001)));
        for (int i = 0; i < 20; i++) begin
            tick();
            req = '0;
        end
        #1;
        check("pre_rst_in_data", 64'({bit_valid, busy}), 64'b11);
        #1;
        rst_b = 1'b0;
        #1;
        check("rst_async_outs", outs(), '0);
        for (int i = 0; i < 3; i++) begin
            tick();
            req = 3'b111;
            #1;
            check("rst_held_outs", outs(), '0);
        end
        tick();
        rst_b = 1'b1;
        req   = '0;
        #1;
        check("rst_release_idle", outs(), '0);
        rr = 0;
        run_packet(3'b110, 0, 1'b0, 1'b1, w, gc, dc);
        check("rst_ptr_winner", 64'(w), 64'd1);
        idle_check("final_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    function automatic int rr_first(input logic [2:0] rq);
        int r;
        r = -1;
        for (int k = 0; k < NREQ; k++) begin
            if (r < 0 && rq[(rr + k) % NREQ]) r = (rr + k) % NREQ;
        end
        return r;
    endfunction

endmodule

// File: doc/usb_tx_sched.md
Name: usb_tx_sched

Overview:
- Transmit-side scheduler for the USB serial path.
- Arbitrates round-robin among NREQ packet sources (token, data, handshake encoders) and latches the winner's PID and payload.
- Serializes SYNC, PID and payload LSB-first into the bit stuffer / NRZI stage, then requests EOP and enforces an inter-packet gap.
- Honours the downstream stall raised while a stuff bit is inserted.

Parameters:
- NREQ, 3, number of requesters.
- MAX_BITS, 64, maximum payload bits per packet; LENW = $clog2(MAX_BITS+1) (local).
- IFG_CYCLES, 2, idle cycles after EOP before the next grant (0 allowed).

Ports:
- clk  in  1  bit-rate clock.
- rst_b  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester send request, level.
- pid  in  NREQ*8  per-requester PID byte (slice i = [8i+7:8i]).
- payload  in  NREQ*MAX_BITS  per-requester payload, bit 0 sent first.
- len  in  NREQ*LENW  per-requester payload bit count.
- stall  in  1  downstream freeze (stuff bit being inserted).
- gnt  out  NREQ  one-hot grant, one-cycle pulse; pid/payload/len of that requester are latched at this edge.
- done  out  NREQ  one-hot one-cycle pulse when the granted packet's EOP completes.
- bit_out  out  1  serial data bit.
- bit_valid  out  1  bit_out is valid this cycle.
- start  out  1  one-cycle pulse on the first SYNC bit.
- eop  out  1  SE0 request to the line driver.
- busy  out  1  high from the cycle after grant through the last GAP cycle.

Behaviour:
- Reset (async): state IDLE, round-robin pointer = 0 (requester 0 highest priority). gnt, done, bit_out, bit_valid, start, eop and busy are all 0. Latched registers are cleared. Reset mid-packet aborts with no done pulse.
- States: IDLE, SYNC, PID, DATA, EOP, GAP.
- IDLE:
  - gnt is combinational and asserted in the same cycle for the first requesting index at or after the pointer, with wraparound.
  - At that edge, latch the slices, set pointer = winner+1 mod NREQ, go to SYNC.
  - No req: stay, all outputs 0.
- SYNC: 8 bits in order 0,0,0,0,0,0,0,1. start=1 only on the first SYNC bit. Then go to PID.
- PID: 8 bits, pid[0] first. Then go to DATA if latched len>0, else EOP.
- DATA: len bits, payload[0] first. Then go to EOP.
- Clamping: len > MAX_BITS is clamped to MAX_BITS at latch time.
- bit_valid=1 on every non-stalled SYNC/PID/DATA cycle.
- stall=1 in SYNC/PID/DATA:
  - Freeze state and bit counter; bit_out holds its value; bit_valid=0; start is delayed until the first unstalled cycle.
  - stall is ignored in IDLE, EOP and GAP.
- EOP: exactly 2 cycles with eop=1, bit_valid=0. done[winner]=1 in the second EOP cycle. Then go to GAP, or IDLE if IFG_CYCLES=0.
- GAP: IFG_CYCLES cycles with all outputs 0 except busy=1. No grant is issued during GAP. Then go to IDLE.
- Latency:
  - First SYNC bit appears the cycle after gnt.
  - Unstalled packet occupies 16+len bit cycles, then 2 EOP cycles, then IFG_CYCLES gap cycles.
  - Earliest next gnt is at cycle gnt+1+16+len+2+IFG_CYCLES.
- req deasserted after grant: ignored; the packet completes.
- req/pid/payload/len changes after grant: no effect on the packet in flight.
- Simultaneous requests: only one gnt bit per grant; the others wait and are never dropped while held.
- gnt and done are never both high for the same requester in one cycle.

Test Plan:
- Single packet, no stall:
  - Stimulus: req=3'b001, pid[7:0]=8'hA5, len=4, payload=4'b1011.
  - Response: gnt=001 at T; bits T+1..T+20 = 0000000 1, 1010 0101, 1101; start at T+1; eop at T+21..T+22; done=001 at T+22; busy low at T+25 (IFG=2).
- Round-robin fairness:
  - Stimulus: req=3'b111 held continuously, all len=0.
  - Response: grant order 001, 010, 100, 001; grants spaced 21 cycles apart.
- Stall mid-PID:
  - Stimulus: stall=1 for 2 cycles after 3rd PID bit.
  - Response: bit_valid=0 for those 2 cycles, bit_out held; remaining 5 PID bits follow unchanged; done delayed by exactly 2 cycles.
- len=0 and len clamp:
  - Stimulus: len=0, then len=100 with MAX_BITS=64.
  - Response: len=0 goes PID to EOP directly (16 valid bits); len=100 sends exactly 64 payload bits.
- Reset mid-DATA:
  - Stimulus: assert rst_b=0 during DATA.
  - Response: all outputs 0 immediately; no done pulse; after release, req=3'b110 grants 010 first (pointer reset to 0).
- Req withdrawn after grant:
  - Stimulus: drop req the cycle after gnt.
  - Response: full packet still sent; done pulses; no regrant.
